mem_ctrl: RTL and testbench

- Single owner of the byte-wide RAM/IO port.
- Arbitrates between instruction fetch (IF, 32-bit word reads) and the load/store buffer (LSB, 1/2/4-byte loads and stores).
- Serialises each access into byte beats, reassembles read data little-endian, and returns a one-cycle done pulse with the value.
- Sits between the IF unit/LSB and the top-level RAM/IO bus.

---
 rtl/mem_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl : single owner of the byte-wide RAM/IO port.
//
// Arbitrates between instruction fetch (32-bit word reads) and the load/store
// buffer (1/2/4-byte loads and stores), serialises each access into byte
// beats, reassembles read data little-endian and returns a one-cycle done
// pulse together with the value.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   rdy             : global enable; low freezes state (mem_wr forced to 0)
//   roll            : misprediction flush (aborts reads, never stores)
//   IF_flag/addr    : fetch request, held until IF_done
//   IF_done/val     : fetch-complete pulse and fetched word
//   LSB_flag/op/addr/len/data : LSB request (op 0 = load, 1 = store)
//   LSB_done/val    : LSB complete pulse and zero-extended load data
//   mem_din         : RAM read byte, valid the cycle mem_a is presented
//   mem_dout/a/wr   : RAM write byte, byte address, write strobe
//   io_buffer_full  : IO write sink cannot accept a byte
//
// Build option
//   MEM_CTRL_RR_EN  : defined -> round-robin arbitration on a tie;
//                     undefined -> fixed priority, LSB over IF.
// -----------------------------------------------------------------------------
module mem_ctrl #(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_HI  = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              roll,
  input  logic              IF_flag,
  input  logic [ADDR_W-1:0] IF_addr,
  output logic              IF_done,
  output logic [31:0]       IF_val,
  input  logic              LSB_flag,
  input  logic              LSB_op,
  input  logic [ADDR_W-1:0] LSB_addr,
  input  logic [2:0]        LSB_len,
  input  logic [31:0]       LSB_data,
  output logic              LSB_done,
  output logic [31:0]       LSB_val,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LSB} owner_t;

  // Any length other than 1 or 2 is handled as a full word.
  function automatic logic [2:0] decode_len(input logic [2:0] len);
    case (len)
      3'd1:    return 3'd1;
      3'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  state_t              r_state, w_state;
  owner_t              r_owner, w_owner;
  logic [2:0]          r_cnt, w_cnt;
  logic [2:0]          r_len, w_len;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [31:0]         r_data, w_data;
  logic [31:0]         r_asm, w_asm;
  logic [ADDR_W-1:0]   r_mem_a, w_mem_a;
  logic                r_mem_wr, w_mem_wr;
  logic [7:0]          r_mem_dout, w_mem_dout;
  logic                r_if_done, w_if_done;
  logic [31:0]         r_if_val, w_if_val;
  logic                r_lsb_done, w_lsb_done;
  logic [31:0]         r_lsb_val, w_lsb_val;

  logic                w_accept;
  logic                w_grant_lsb;
  logic                w_io_stall;
  logic [1:0]          w_rd_idx;

  assign w_accept   = (r_state == ST_IDLE) && !roll && (IF_flag || LSB_flag);
  assign w_io_stall = (r_addr[17:16] == IO_HI) && io_buffer_full;
  // Byte slot being captured this cycle: cnt runs one ahead of the data.
  assign w_rd_idx   = r_cnt[1:0] - 2'd1;

`ifdef MEM_CTRL_RR_EN
  // Last-winner bit: 0 = IF, 1 = LSB. Resets to IF so LSB takes the first tie.
  logic r_last_lsb;

  assign w_grant_lsb = LSB_flag && (!IF_flag || !r_last_lsb);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_lsb <= 1'b0;
    end else if (rdy && w_accept) begin
      r_last_lsb <= w_grant_lsb;
    end
  end
`else
  assign w_grant_lsb = LSB_flag;
`endif

  // Next-state and next-output logic
  always_comb begin
    w_state    = r_state;
    w_owner    = r_owner;
    w_cnt      = r_cnt;
    w_len      = r_len;
    w_addr     = r_addr;
    w_data     = r_data;
    w_asm      = r_asm;
    w_mem_a    = r_mem_a;
    w_mem_wr   = 1'b0;
    w_mem_dout = r_mem_dout;
    w_if_done  = 1'b0;
    w_if_val   = r_if_val;
    w_lsb_done = 1'b0;
    w_lsb_val  = r_lsb_val;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_asm = 32'd0;
          if (w_grant_lsb) begin
            w_owner = OWN_LSB;
            w_addr  = LSB_addr;
            w_len   = decode_len(LSB_len);
            w_data  = LSB_data;
          end else begin
            w_owner = OWN_IF;
            w_addr  = IF_addr;
            w_len   = 3'd4;
            w_data  = 32'd0;
          end
          w_mem_a = w_addr;
          if (w_grant_lsb && LSB_op) begin
            w_state = ST_WRITE;
            w_cnt   = 3'd0;
          end else begin
            w_state = ST_READ;
            w_cnt   = 3'd1;
          end
        end
      end

      ST_READ: begin
        if (roll) begin
          // Flushed fetch/load: drop it silently, nobody sees data.
          w_state = ST_IDLE;
          w_owner = OWN_NONE;
          w_cnt   = 3'd0;
        end else begin
          w_asm[{w_rd_idx, 3'b000} +: 8] = mem_din;
          if (r_cnt < r_len) begin
            w_mem_a = r_addr + ADDR_W'(r_cnt);
            w_cnt   = r_cnt + 3'd1;
          end else begin
            w_state = ST_DONE;
            if (r_owner == OWN_LSB) begin
              w_lsb_done = 1'b1;
              w_lsb_val  = w_asm;
            end else begin
              w_if_done  = 1'b1;
              w_if_val   = w_asm;
            end
          end
        end
      end

      ST_WRITE: begin
        // Stores are committed, so roll is deliberately ignored here.
        if (!w_io_stall) begin
          w_mem_wr   = 1'b1;
          w_mem_a    = r_addr + ADDR_W'(r_cnt);
          w_mem_dout = r_data[{r_cnt[1:0], 3'b000} +: 8];
          w_cnt      = r_cnt + 3'd1;
          if (r_cnt == r_len - 3'd1) begin
            w_state    = ST_DONE;
            w_lsb_done = 1'b1;
          end
        end
      end

      ST_DONE: begin
        // Requester is still lowering its flag; accept nothing this cycle.
        w_state = ST_IDLE;
        w_owner = OWN_NONE;
        w_cnt   = 3'd0;
      end

      default: begin
        w_state = ST_IDLE;
        w_owner = OWN_NONE;
        w_cnt   = 3'd0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_owner    <= OWN_NONE;
      r_cnt      <= 3'd0;
      r_len      <= 3'd0;
      r_addr     <= '0;
      r_data     <= 32'd0;
      r_asm      <= 32'd0;
      r_mem_a    <= '0;
      r_mem_wr   <= 1'b0;
      r_mem_dout <= 8'd0;
      r_if_done  <= 1'b0;
      r_if_val   <= 32'd0;
      r_lsb_done <= 1'b0;
      r_lsb_val  <= 32'd0;
    end else if (!rdy) begin
      r_mem_wr   <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_owner    <= w_owner;
      r_cnt      <= w_cnt;
      r_len      <= w_len;
      r_addr     <= w_addr;
      r_data     <= w_data;
      r_asm      <= w_asm;
      r_mem_a    <= w_mem_a;
      r_mem_wr   <= w_mem_wr;
      r_mem_dout <= w_mem_dout;
      r_if_done  <= w_if_done;
      r_if_val   <= w_if_val;
      r_lsb_done <= w_lsb_done;
      r_lsb_val  <= w_lsb_val;
    end
  end

  assign IF_done  = r_if_done;
  assign IF_val   = r_if_val;
  assign LSB_done = r_lsb_done;
  assign LSB_val  = r_lsb_val;
  assign mem_a    = r_mem_a;
  assign mem_wr   = r_mem_wr;
  assign mem_dout = r_mem_dout;

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl : directed self-checking bench for mem_ctrl.
// Inputs are driven and outputs sampled on the falling clock edge. The RAM
// model returns the byte at mem_a combinationally; write beats are logged on
// the falling edge so each beat is recorded exactly once.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, roll;
  logic        IF_flag, IF_done;
  logic [31:0] IF_addr, IF_val;
  logic        LSB_flag, LSB_op, LSB_done;
  logic [31:0] LSB_addr, LSB_data, LSB_val;
  logic [2:0]  LSB_len;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;

  int checks   = 0;
  int failures = 0;
  int base;

  logic [7:0]  ram [0:262143];
  logic [31:0] wlog_a[$];
  logic [7:0]  wlog_d[$];

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .roll           (roll),
    .IF_flag        (IF_flag),
    .IF_addr        (IF_addr),
    .IF_done        (IF_done),
    .IF_val         (IF_val),
    .LSB_flag       (LSB_flag),
    .LSB_op         (LSB_op),
    .LSB_addr       (LSB_addr),
    .LSB_len        (LSB_len),
    .LSB_data       (LSB_data),
    .LSB_done       (LSB_done),
    .LSB_val        (LSB_val),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  assign mem_din = ram[mem_a[17:0]];

  always @(negedge clk) begin
    if (mem_wr === 1'b1) begin
      wlog_a.push_back(mem_a);
      wlog_d.push_back(mem_dout);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Checks the n beats logged from index b against consecutive addresses.
  task automatic chk_beats(input string tag, input int b, input logic [31:0] a0,
                           input logic [31:0] data, input int n);
    chk({tag, "_nbeats"}, wlog_a.size() - b, n);
    if (wlog_a.size() >= b + n) begin
      for (int i = 0; i < n; i++) begin
        chk({tag, "_addr"}, wlog_a[b+i], a0 + i);
        chk({tag, "_data"}, {24'd0, wlog_d[b+i]}, {24'd0, data[8*i +: 8]});
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
    ram[18'h00100] = 8'h13; ram[18'h00101] = 8'h05;
    ram[18'h00102] = 8'h00; ram[18'h00103] = 8'h00;
    ram[18'h02001] = 8'hFF; ram[18'h02002] = 8'h80;
    ram[18'h02003] = 8'h7E; ram[18'h02004] = 8'h01;
    ram[18'h3FFFF] = 8'hAA; ram[18'h00000] = 8'h11;
    ram[18'h00001] = 8'h22; ram[18'h00002] = 8'h33;

    rst = 1'b1; rdy = 1'b1; roll = 1'b0; io_buffer_full = 1'b0;
    IF_flag = 1'b0; IF_addr = 32'd0;
    LSB_flag = 1'b0; LSB_op = 1'b0; LSB_addr = 32'd0; LSB_len = 3'd0; LSB_data = 32'd0;

    // Reset state
    cyc(2);
    chk("rst_if_done",  {31'd0, IF_done}, 32'd0);
    chk("rst_lsb_done", {31'd0, LSB_done}, 32'd0);
    chk("rst_if_val",   IF_val, 32'd0);
    chk("rst_lsb_val",  LSB_val, 32'd0);
    chk("rst_mem_a",    mem_a, 32'd0);
    chk("rst_mem_wr",   {31'd0, mem_wr}, 32'd0);
    chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    rst = 1'b0;
    cyc(1);

    // Instruction fetch of a full word
    IF_addr = 32'h100; IF_flag = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc(1);
      chk("if_mem_a", mem_a, 32'h100 + i - 1);
      chk("if_early_done", {31'd0, IF_done}, 32'd0);
    end
    cyc(1);
    chk("if_done", {31'd0, IF_done}, 32'd1);
    chk("if_val", IF_val, 32'h00000513);
    IF_flag = 1'b0;
    cyc(1);
    chk("if_done_pulse", {31'd0, IF_done}, 32'd0);
    chk("if_val_hold", IF_val, 32'h00000513);

    // Two-byte load
    base = wlog_a.size();
    LSB_flag = 1'b1; LSB_op = 1'b0; LSB_addr = 32'h2001; LSB_len = 3'd2;
    cyc(2);
    chk("lh_early_done", {31'd0, LSB_done}, 32'd0);
    chk("lh_no_wr", {31'd0, mem_wr}, 32'd0);
    cyc(1);
    chk("lh_done", {31'd0, LSB_done}, 32'd1);
    chk("lh_val", LSB_val, 32'h000080FF);
    LSB_flag = 1'b0;
    cyc(1);
    chk("lh_no_beats", wlog_a.size() - base, 32'd0);

    // Word store to the IO region with a two-cycle sink stall
    base = wlog_a.size();
    LSB_flag = 1'b1; LSB_op = 1'b1; LSB_addr = 32'h30000; LSB_len = 3'd4;
    LSB_data = 32'h44332211;
    cyc(2);
    io_buffer_full = 1'b1;
    cyc(1);
    chk("io_stall1", {31'd0, mem_wr}, 32'd0);
    cyc(1);
    chk("io_stall2", {31'd0, mem_wr}, 32'd0);
    chk("io_early_done", {31'd0, LSB_done}, 32'd0);
    io_buffer_full = 1'b0;
    cyc(3);
    chk("io_done", {31'd0, LSB_done}, 32'd1);
    chk("io_last_beat", {31'd0, mem_wr}, 32'd1);
    LSB_flag = 1'b0;
    cyc(1);
    chk("io_done_pulse", {31'd0, LSB_done}, 32'd0);
    chk_beats("io", base, 32'h30000, 32'h44332211, 4);

    // Simultaneous requests: LSB first, IF right after the LSB's DONE cycle
    LSB_op = 1'b0; LSB_addr = 32'h2001; LSB_len = 3'd1; IF_addr = 32'h100;
    LSB_flag = 1'b1; IF_flag = 1'b1;
    cyc(2);
    chk("tie_lsb_done", {31'd0, LSB_done}, 32'd1);
    chk("tie_if_wait", {31'd0, IF_done}, 32'd0);
    chk("tie_lsb_val", LSB_val, 32'h000000FF);
    LSB_flag = 1'b0;
    cyc(2);
    chk("tie_if_mem_a", mem_a, 32'h100);
    cyc(3);
    chk("tie_if_early", {31'd0, IF_done}, 32'd0);
    cyc(1);
    chk("tie_if_done", {31'd0, IF_done}, 32'd1);
    IF_flag = 1'b0;
    cyc(1);

    // roll in IDLE blocks acceptance for that cycle
    LSB_flag = 1'b1; LSB_addr = 32'h2002; LSB_len = 3'd1; roll = 1'b1;
    cyc(1);
    chk("roll_idle_mem_a", mem_a, 32'h103);
    roll = 1'b0;
    cyc(2);
    chk("roll_idle_done", {31'd0, LSB_done}, 32'd1);
    chk("roll_idle_val", LSB_val, 32'h00000080);
    LSB_flag = 1'b0;
    cyc(1);

    // roll during a fetch aborts it
    IF_addr = 32'h2001; IF_flag = 1'b1;
    cyc(2);
    roll = 1'b1; IF_flag = 1'b0;
    cyc(1);
    chk("roll_rd_mem_a", mem_a, 32'h2002);
    chk("roll_rd_no_done", {31'd0, IF_done}, 32'd0);
    roll = 1'b0;
    LSB_flag = 1'b1; LSB_addr = 32'h2001; LSB_len = 3'd1;
    cyc(1);
    chk("roll_rd_no_done2", {31'd0, IF_done}, 32'd0);
    cyc(1);
    chk("roll_rd_idle_accept", {31'd0, LSB_done}, 32'd1);
    chk("roll_rd_if_val", IF_val, 32'h00000513);
    LSB_flag = 1'b0;
    cyc(1);

    // roll during a store does not abort it
    base = wlog_a.size();
    LSB_flag = 1'b1; LSB_op = 1'b1; LSB_addr = 32'h400; LSB_len = 3'd4;
    LSB_data = 32'hDDCCBBAA;
    cyc(2);
    roll = 1'b1;
    cyc(1);
    roll = 1'b0;
    cyc(1);
    chk("roll_sw_early", {31'd0, LSB_done}, 32'd0);
    cyc(1);
    chk("roll_sw_done", {31'd0, LSB_done}, 32'd1);
    LSB_flag = 1'b0;
    cyc(1);
    chk_beats("roll_sw", base, 32'h400, 32'hDDCCBBAA, 4);

    // rdy low for three cycles mid-read
    LSB_flag = 1'b1; LSB_op = 1'b0; LSB_addr = 32'h2001; LSB_len = 3'd4;
    cyc(1);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("rdy_rd_mem_a", mem_a, 32'h2001);
      chk("rdy_rd_mem_wr", {31'd0, mem_wr}, 32'd0);
    end
    rdy = 1'b1;
    cyc(3);
    chk("rdy_rd_early", {31'd0, LSB_done}, 32'd0);
    cyc(1);
    chk("rdy_rd_done", {31'd0, LSB_done}, 32'd1);
    chk("rdy_rd_val", LSB_val, 32'h017E80FF);
    LSB_flag = 1'b0;
    cyc(1);

    // rdy low during a store: strobe drops, no beat lost or repeated
    base = wlog_a.size();
    LSB_flag = 1'b1; LSB_op = 1'b1; LSB_addr = 32'h500; LSB_len = 3'd2;
    LSB_data = 32'h00006655;
    cyc(2);
    chk("rdy_wr_beat0", {31'd0, mem_wr}, 32'd1);
    rdy = 1'b0;
    cyc(1);
    chk("rdy_wr_forced0", {31'd0, mem_wr}, 32'd0);
    rdy = 1'b1;
    cyc(1);
    chk("rdy_wr_done", {31'd0, LSB_done}, 32'd1);
    LSB_flag = 1'b0;
    cyc(1);
    chk_beats("rdy_wr", base, 32'h500, 32'h00006655, 2);

    // Illegal length 3 behaves as a word
    LSB_flag = 1'b1; LSB_op = 1'b0; LSB_addr = 32'h2001; LSB_len = 3'd3;
    cyc(4);
    chk("len3_early", {31'd0, LSB_done}, 32'd0);
    cyc(1);
    chk("len3_done", {31'd0, LSB_done}, 32'd1);
    chk("len3_val", LSB_val, 32'h017E80FF);
    LSB_flag = 1'b0;
    cyc(1);

    // Address wraps modulo 2^32
    IF_addr = 32'hFFFFFFFF; IF_flag = 1'b1;
    cyc(1);
    chk("wrap_a0", mem_a, 32'hFFFFFFFF);
    cyc(1);
    chk("wrap_a1", mem_a, 32'h00000000);
    cyc(3);
    chk("wrap_done", {31'd0, IF_done}, 32'd1);
    chk("wrap_val", IF_val, 32'h332211AA);
    IF_flag = 1'b0;
    cyc(1);

    // Asynchronous reset mid-transfer: outputs clear, no done pulse
    IF_addr = 32'h100; IF_flag = 1'b1;
    cyc(2);
    rst = 1'b1;
    #1;
    chk("rst_mid_mem_a", mem_a, 32'd0);
    chk("rst_mid_if_val", IF_val, 32'd0);
    cyc(1);
    rst = 1'b0; IF_flag = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("rst_mid_no_done", {31'd0, IF_done}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
